// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                              |
// | Description : Shares one UART transmitter between two byte requesters.     |
// |               Round-robin arbitration with line-atomic locking, and a      |
// |               strobe/guard/busy sequence for every byte sent.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter logic [7:0]  EOL          = 8'h0A,
  parameter bit          LOCK_EN      = 1'b1,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_wr,
  output logic [7:0] uart_w,
  input  logic       uart_busy,
  output logic       lock_active,
  output logic       lock_owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(LOCK_TIMEOUT);

  state_t      state_q, state_d;
  logic        uart_wr_q, uart_wr_d;
  logic [7:0]  uart_w_q, uart_w_d;
  logic        lock_active_q, lock_active_d;
  logic        lock_owner_q, lock_owner_d;
  // Round-robin pointer: 0 favours req0, 1 favours req1.
  logic        rr_q, rr_d;
  logic [15:0] tmo_q, tmo_d;

  logic        gnt0;
  logic        gnt1;
  logic [7:0]  win_data;

  // Grant selection; only IDLE grants, and readies stay low while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_IDLE && resetq) begin
      if (lock_active_q) begin
        // A held line lock admits only its owner, even when the owner is quiet.
        gnt0 = req0_valid && !lock_owner_q;
        gnt1 = req1_valid &&  lock_owner_q;
      end else if (req0_valid && req1_valid) begin
        gnt0 = !rr_q;
        gnt1 =  rr_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign win_data = gnt1 ? req1_data : req0_data;

  // Next-state, byte capture, lock bookkeeping and idle-timeout counting.
  always_comb begin
    state_d       = state_q;
    uart_wr_d     = 1'b0;
    uart_w_d      = uart_w_q;
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    rr_d          = rr_q;
    tmo_d         = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          state_d       = ST_SEND;
          uart_wr_d     = 1'b1;
          uart_w_d      = win_data;
          lock_owner_d  = gnt1;
          rr_d          = !gnt1;
          tmo_d         = '0;
          // A non-EOL byte opens (or keeps) the line lock; EOL closes it.
          lock_active_d = LOCK_EN && (win_data != EOL);
        end else if (lock_active_q) begin
          // Owner is silent while holding the lock: age it toward release.
          if (tmo_q >= TMO_LIMIT - 16'd1) begin
            tmo_d         = TMO_LIMIT;
            lock_active_d = 1'b0;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
      end
      ST_SEND:  state_d = ST_GUARD;
      // The TX core raises busy a cycle late, so it is not looked at here.
      ST_GUARD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!uart_busy) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    if (!lock_active_q) begin
      tmo_d = '0;
    end
  end

  // State register; the strobe is a flop so it cannot glitch on reset release.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q       <= ST_IDLE;
      uart_wr_q     <= 1'b0;
      uart_w_q      <= 8'h00;
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
      rr_q          <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      uart_wr_q     <= uart_wr_d;
      uart_w_q      <= uart_w_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      rr_q          <= rr_d;
      tmo_q         <= tmo_d;
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign uart_wr     = uart_wr_q;
  assign uart_w      = uart_w_q;
  assign lock_active = lock_active_q;
  assign lock_owner  = lock_owner_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                           |
// | Description : Self-checking bench for uart_tx_arbiter: directed scenarios  |
// |               plus randomized byte streams against a transaction model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam logic [7:0] EOL_B = 8'h0A;

  logic       clk;
  logic       resetq;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       uart_wr;
  logic [7:0] uart_w;
  logic       uart_busy;
  logic       lock_active;
  logic       lock_owner;

  int checks;
  int errors;

  uart_tx_arbiter #(
    .EOL         (EOL_B),
    .LOCK_EN     (1'b1),
    .LOCK_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .resetq     (resetq),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .uart_wr    (uart_wr),
    .uart_w     (uart_w),
    .uart_busy  (uart_busy),
    .lock_active(lock_active),
    .lock_owner (lock_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; outputs are sampled on falling edges.
  task automatic do_reset();
    resetq     = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'h00;
    req1_data  = 8'h00;
    uart_busy  = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetq = 1'b1;
  endtask

  task automatic test_reset();
    resetq     = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 8'h41;
    req1_valid = 1'b1;
    req1_data  = 8'h58;
    uart_busy  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy0 got %b exp 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy1 got %b exp 0", req1_ready); end
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", uart_wr); end
    checks++; if (uart_w !== 8'h00) begin errors++; $display("FAIL reset_w got %h exp 00", uart_w); end
    checks++; if (lock_active !== 1'b0) begin errors++; $display("FAIL reset_lock got %b exp 0", lock_active); end
    checks++; if (lock_owner !== 1'b0) begin errors++; $display("FAIL reset_owner got %b exp 0", lock_owner); end
    @(posedge clk);
    #1 resetq = 1'b1;
    @(negedge clk);
    // Both valid straight out of reset: pointer must favour req0.
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ptr got %b%b exp 10", req0_ready, req1_ready);
    end
  endtask

  task automatic test_single();
    logic e_rdy, e_wr;
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 8'h41;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      e_rdy = (c == 0) || (c == 4);
      e_wr  = (c == 1) || (c == 5);
      checks++; if (req0_ready !== e_rdy) begin errors++; $display("FAIL single_rdy0 c=%0d got %b exp %b", c, req0_ready, e_rdy); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_rdy1 c=%0d got %b exp 0", c, req1_ready); end
      checks++; if (uart_wr !== e_wr) begin errors++; $display("FAIL single_wr c=%0d got %b exp %b", c, uart_wr, e_wr); end
      if (c >= 1 && c <= 4) begin
        checks++; if (uart_w !== 8'h41) begin errors++; $display("FAIL single_w c=%0d got %h exp 41", c, uart_w); end
        checks++; if (lock_active !== 1'b1 || lock_owner !== 1'b0) begin
          errors++; $display("FAIL single_lock c=%0d got %b/%b exp 1/0", c, lock_active, lock_owner);
        end
      end
      if (c == 5) begin
        checks++; if (uart_w !== EOL_B) begin errors++; $display("FAIL single_w_eol got %h exp 0a", uart_w); end
      end
      if (c == 8) begin
        checks++; if (lock_active !== 1'b0) begin errors++; $display("FAIL single_unlock got %b exp 0", lock_active); end
      end
      @(posedge clk); #1;
      if (c == 0) req0_data = EOL_B;
      if (c == 4) req0_valid = 1'b0;
    end
  endtask

  task automatic test_alternate();
    logic e0, e1, e_wr;
    do_reset();
    req0_valid = 1'b1; req0_data = EOL_B;
    req1_valid = 1'b1; req1_data = EOL_B;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      e0   = (c % 4 == 0) && ((c / 4) % 2 == 0);
      e1   = (c % 4 == 0) && ((c / 4) % 2 == 1);
      e_wr = (c % 4 == 1);
      checks++; if (req0_ready !== e0 || req1_ready !== e1) begin
        errors++; $display("FAIL alt_rdy c=%0d got %b%b exp %b%b", c, req0_ready, req1_ready, e0, e1);
      end
      checks++; if (uart_wr !== e_wr) begin errors++; $display("FAIL alt_wr c=%0d got %b exp %b", c, uart_wr, e_wr); end
      checks++; if (lock_active !== 1'b0) begin errors++; $display("FAIL alt_lock c=%0d got %b exp 0", c, lock_active); end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_lock();
    logic e0, e1, e_wr, e_la, e_own;
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h41;
    req1_valid = 1'b1; req1_data = 8'h58;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      e0    = (c == 0) || (c == 7) || (c == 11);
      e1    = (c == 15);
      e_wr  = (c == 1) || (c == 8) || (c == 12) || (c == 16);
      e_la  = (c >= 1 && c <= 11) || (c >= 16);
      e_own = (c >= 16);
      checks++; if (req0_ready !== e0 || req1_ready !== e1) begin
        errors++; $display("FAIL lock_rdy c=%0d got %b%b exp %b%b", c, req0_ready, req1_ready, e0, e1);
      end
      checks++; if (uart_wr !== e_wr) begin errors++; $display("FAIL lock_wr c=%0d got %b exp %b", c, uart_wr, e_wr); end
      checks++; if (lock_active !== e_la || lock_owner !== e_own) begin
        errors++; $display("FAIL lock_state c=%0d got %b/%b exp %b/%b", c, lock_active, lock_owner, e_la, e_own);
      end
      if (c == 8) begin
        checks++; if (uart_w !== 8'h42) begin errors++; $display("FAIL lock_w_b got %h exp 42", uart_w); end
      end
      if (c == 16) begin
        checks++; if (uart_w !== 8'h58) begin errors++; $display("FAIL lock_w_x got %h exp 58", uart_w); end
      end
      @(posedge clk); #1;
      if (c == 0)  req0_valid = 1'b0;
      if (c == 6)  begin req0_valid = 1'b1; req0_data = 8'h42; end
      if (c == 7)  req0_data = EOL_B;
      if (c == 11) req0_valid = 1'b0;
      if (c == 15) req1_valid = 1'b0;
    end
  endtask

  task automatic test_busy();
    logic e0, e1, e_wr;
    do_reset();
    req0_valid = 1'b1; req0_data = EOL_B;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      e0   = (c == 0);
      e1   = (c == 23);
      e_wr = (c == 1) || (c == 24);
      checks++; if (req0_ready !== e0 || req1_ready !== e1) begin
        errors++; $display("FAIL busy_rdy c=%0d got %b%b exp %b%b", c, req0_ready, req1_ready, e0, e1);
      end
      checks++; if (uart_wr !== e_wr) begin errors++; $display("FAIL busy_wr c=%0d got %b exp %b", c, uart_wr, e_wr); end
      @(posedge clk); #1;
      if (c == 0)  req0_valid = 1'b0;
      if (c == 1)  begin uart_busy = 1'b1; req1_valid = 1'b1; req1_data = EOL_B; end
      if (c == 21) uart_busy = 1'b0;
      if (c == 23) req1_valid = 1'b0;
    end
  endtask

  task automatic test_timeout();
    logic e1, e_la;
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h41;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      e1   = (c == 12);
      e_la = (c >= 1 && c <= 11) || (c == 13);
      checks++; if (req0_ready !== (c == 0) || req1_ready !== e1) begin
        errors++; $display("FAIL tmo_rdy c=%0d got %b%b exp %b%b", c, req0_ready, req1_ready, (c == 0), e1);
      end
      checks++; if (lock_active !== e_la) begin errors++; $display("FAIL tmo_lock c=%0d got %b exp %b", c, lock_active, e_la); end
      if (c == 13) begin
        checks++; if (uart_wr !== 1'b1 || uart_w !== 8'h58 || lock_owner !== 1'b1) begin
          errors++; $display("FAIL tmo_send got wr=%b w=%h own=%b exp wr=1 w=58 own=1", uart_wr, uart_w, lock_owner);
        end
      end
      @(posedge clk); #1;
      if (c == 0)  begin req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 8'h58; end
      if (c == 12) req1_valid = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req1_valid = 1'b1; req1_data = 8'h41;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (req1_ready !== (c == 0) || uart_wr !== (c == 1)) begin
        errors++; $display("FAIL ar_pre c=%0d got rdy=%b wr=%b exp rdy=%b wr=%b", c, req1_ready, uart_wr, (c == 0), (c == 1));
      end
      @(posedge clk); #1;
      if (c == 0) req1_valid = 1'b0;
      if (c == 1) uart_busy = 1'b1;
    end
    checks++; if (lock_active !== 1'b1 || lock_owner !== 1'b1 || uart_w !== 8'h41) begin
      errors++; $display("FAIL ar_wait got la=%b own=%b w=%h exp la=1 own=1 w=41", lock_active, lock_owner, uart_w);
    end
    // Assert reset between clock edges while parked in WAIT.
    #2 resetq = 1'b0;
    #1;
    checks++; if (uart_wr !== 1'b0 || uart_w !== 8'h00 || lock_active !== 1'b0 || lock_owner !== 1'b0) begin
      errors++; $display("FAIL ar_outs got wr=%b w=%h la=%b own=%b exp all 0", uart_wr, uart_w, lock_active, lock_owner);
    end
    uart_busy  = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 8'h33;
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL ar_rdy_in_reset got %b%b exp 00", req0_ready, req1_ready);
    end
    @(posedge clk);
    #3 resetq = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || uart_wr !== 1'b0) begin
      errors++; $display("FAIL ar_grant got rdy=%b wr=%b exp rdy=1 wr=0", req0_ready, uart_wr);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || uart_w !== 8'h33) begin
      errors++; $display("FAIL ar_strobe got wr=%b w=%h exp wr=1 w=33", uart_wr, uart_w);
    end
    @(negedge clk);
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL ar_strobe_len got %b exp 0", uart_wr); end
  endtask

  // Transaction-level model: each requester is a byte queue; the model predicts
  // who wins the next grant from the lock/round-robin rules only.
  task automatic test_random(input int round);
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] b;
    logic       fav, locked, owner, has0, has1, exp_win, got;
    logic       pend, pend_la, pend_own;
    logic [7:0] pend_byte;
    int         n0, n1, last_gnt, cyc;

    n0 = $urandom_range(3, 12);
    n1 = $urandom_range(3, 12);
    for (int i = 0; i < n0 + n1; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) b = EOL_B;
      else if (b == EOL_B) b = 8'h41;
      if (i < n0) q0.push_back(b);
      else        q1.push_back(b);
    end

    do_reset();
    fav = 1'b0; locked = 1'b0; owner = 1'b0;
    pend = 1'b0; pend_la = 1'b0; pend_own = 1'b0; pend_byte = 8'h00;
    last_gnt = -100;
    req0_valid = 1'b1; req0_data = q0[0];
    req1_valid = 1'b1; req1_data = q1[0];

    for (cyc = 0; cyc < 4000 && (q0.size() != 0 || q1.size() != 0 || pend); cyc++) begin
      @(negedge clk);
      checks++; if (uart_wr !== pend) begin
        errors++; $display("FAIL rnd%0d_wr cyc=%0d got %b exp %b", round, cyc, uart_wr, pend);
      end
      if (pend) begin
        checks++; if (uart_w !== pend_byte || lock_active !== pend_la || lock_owner !== pend_own) begin
          errors++; $display("FAIL rnd%0d_byte cyc=%0d got w=%h la=%b own=%b exp w=%h la=%b own=%b",
                             round, cyc, uart_w, lock_active, lock_owner, pend_byte, pend_la, pend_own);
        end
        pend = 1'b0;
      end
      if (req0_ready && req1_ready) begin
        errors++; checks++;
        $display("FAIL rnd%0d_double cyc=%0d got 11 exp one-hot", round, cyc);
      end else if (req0_ready || req1_ready) begin
        has0 = (q0.size() != 0);
        has1 = (q1.size() != 0);
        // A lock whose owner has run dry can only end by timeout.
        if (locked && !(owner ? has1 : has0)) locked = 1'b0;
        if (locked)              exp_win = owner;
        else if (has0 && has1)   exp_win = fav;
        else                     exp_win = has1;
        got = req1_ready;
        checks++; if (got !== exp_win) begin
          errors++; $display("FAIL rnd%0d_winner cyc=%0d got %b exp %b", round, cyc, got, exp_win);
        end
        checks++; if (cyc - last_gnt < 4) begin
          errors++; $display("FAIL rnd%0d_gap cyc=%0d got %0d exp >=4", round, cyc, cyc - last_gnt);
        end
        last_gnt = cyc;
        if ((got ? q1.size() : q0.size()) == 0) begin
          errors++; checks++;
          $display("FAIL rnd%0d_empty cyc=%0d got grant exp none", round, cyc);
        end else begin
          pend_byte = got ? q1.pop_front() : q0.pop_front();
          fav       = !got;
          owner     = got;
          locked    = (pend_byte != EOL_B);
          pend      = 1'b1;
          pend_la   = locked;
          pend_own  = got;
        end
      end
      @(posedge clk); #1;
      req0_valid = (q0.size() != 0);
      req1_valid = (q1.size() != 0);
      if (q0.size() != 0) req0_data = q0[0];
      if (q1.size() != 0) req1_data = q1[0];
      uart_busy = ($urandom_range(0, 2) == 0);
    end
    if (q0.size() != 0 || q1.size() != 0 || pend) begin
      errors++;
      $display("FAIL rnd%0d_budget got %0d/%0d bytes left exp 0/0", round, q0.size(), q1.size());
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    uart_busy  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_busy();
    test_timeout();
    test_async_reset();
    for (int r = 0; r < 4; r++) test_random(r);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART0 transmitter between two byte requesters: req0 (CPU io bus, IO address bit 12 write path) and req1 (debug/trace source).
- Round-robin arbitration with line-atomic locking, so one requester's text line is never interleaved with the other's.
- Sequences every byte through the strobe/busy handshake of the transmitter.
- Sits between the j1 io bus glue and the UART TX core in the SoC top.

Parameters:
- EOL, 8'h0A, byte that ends a line and releases the lock.
- LOCK_EN, 1, 1 enables line locking; 0 gives pure per-byte round-robin.
- LOCK_TIMEOUT, 1024, idle cycles without owner traffic before a held lock is force-released; valid range 2..65535.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetq  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  8  requester 0 byte
- req0_ready  out  1  byte from requester 0 accepted this cycle
- req1_valid  in  1  requester 1 has a byte
- req1_data  in  8  requester 1 byte
- req1_ready  out  1  byte from requester 1 accepted this cycle
- uart_wr  out  1  one-cycle transmit strobe to the UART TX core
- uart_w  out  8  byte presented with uart_wr; registered, held until next grant
- uart_busy  in  1  UART TX core busy
- lock_active  out  1  a line lock is held
- lock_owner  out  1  requester holding the lock, or last granted when unlocked

Behaviour:
- Reset (resetq low, async): state=IDLE, uart_wr=0, uart_w=0, req0_ready=req1_ready=0, lock_active=0, lock_owner=0, round-robin pointer favours req0, timeout counter=0. Reset mid-byte abandons the byte; uart_wr never glitches high on release.
- FSM states: IDLE, SEND, GUARD, WAIT.
- IDLE:
  - Picks a winner among valid requesters; the winner's reqN_ready=1 combinationally in that cycle (valid&ready handshake).
  - The winner's data is registered into uart_w. Next state is SEND.
  - No valid requester: stay in IDLE.
- SEND: uart_wr=1 for exactly one cycle, then GUARD.
- GUARD: one cycle, ignores uart_busy to cover one-cycle busy lag in the TX core, then WAIT.
- WAIT: stay while uart_busy=1; go to IDLE on the first cycle uart_busy=0.
- Throughput: minimum 4 cycles per byte, reached when busy never asserts. The ready pulse is at cycle N and uart_wr at N+1.
- Arbitration when unlocked:
  - If both requesters are valid, the one not granted last wins.
  - If only one is valid, it wins regardless of the pointer.
  - The pointer updates on every grant.
- Arbitration when locked (lock_active=1): only lock_owner may be granted; the other requester's ready stays 0 even if the owner is idle.
- Lock update on grant, when LOCK_EN=1:
  - Byte != EOL: lock_active<=1, lock_owner<=winner.
  - Byte == EOL: lock_active<=0; lock_owner<=winner; the pointer then favours the other requester.
- LOCK_EN=0: lock_active is constant 0.
- Timeout counter:
  - Counts cycles in IDLE while lock_active=1 and the owner is not valid; it is clamped at LOCK_TIMEOUT.
  - Cleared on any grant and when lock_active=0.
  - On reaching LOCK_TIMEOUT, lock_active<=0; arbitration is unlocked from the next cycle.
- Simultaneous events:
  - Timeout reached in the same cycle the owner raises valid: the owner is granted and the counter is cleared; the lock is not dropped.
  - Both requesters valid in the same cycle as the lock release: the release takes effect next cycle; the lock rules apply this cycle.
- Requesters may drop valid before ready without penalty; the data must be stable only in the ready cycle.
- uart_busy asserted while in IDLE does not block a grant. The TX core is responsible for accepting only when not busy, so the CPU polls !busy before writing.

Test Plan:
- Reset, then req0 sends 8'h41 with uart_busy=0: req0_ready at cycle 0, uart_wr=1 with uart_w=8'h41 at cycle 1, back in IDLE at cycle 4; lock_active=1, lock_owner=0.
- Both valid, unlocked: req0 8'h0A then req1 8'h0A alternate, then req0 again; ready pulses alternate strictly, with no double grant to one requester.
- Locking: req0 streams "AB\n" while req1 is held valid with 8'h58: req1_ready stays 0 until the 8'h0A byte is granted, then req1 is granted in the next IDLE.
- Busy stretch: uart_busy high for 20 cycles starting at the GUARD cycle: the FSM stays in WAIT, no ready or uart_wr pulses, and it resumes one cycle after busy falls.
- Timeout: LOCK_TIMEOUT=8, req0 sends 8'h41 (no EOL) then goes idle while req1 is valid: req1_ready is 0 for 8 idle cycles, lock_active falls, and req1 is granted the cycle after.
- Async reset asserted during the WAIT state: all outputs go to reset values immediately; after release, an IDLE grant to req0 works with uart_wr a single-cycle pulse.
